// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: control/status bundle between the LEGv8 sequencer and its datapath.
// Perf counter signals exist only when DATAPATH_SEQ_PERF_EN is defined.
interface datapath_sequencer_if;
    logic        run;
    logic [11:0] instr;
    logic [3:0]  flags;
    logic        commandZero;
    logic        mem_ready;
    logic        uncondBr;
    logic        brTaken;
    logic        memWrite;
    logic        memToReg;
    logic        ALUSrc;
    logic        regWrite;
    logic        reg2Loc;
    logic        valueToStore;
    logic        dOrImm;
    logic        BRMI;
    logic        saveCond;
    logic        read_enable;
    logic [2:0]  ALUOp;
    logic [4:0]  regRD;
    logic        pc_en;
    logic        halted;
    logic        busy;
`ifdef DATAPATH_SEQ_PERF_EN
    logic [31:0] retired;
    logic [31:0] stall_cycles;
`endif

    modport master (
        output run, instr, flags, commandZero, mem_ready,
`ifdef DATAPATH_SEQ_PERF_EN
        input  retired, stall_cycles,
`endif
        input  uncondBr, brTaken, memWrite, memToReg, ALUSrc, regWrite, reg2Loc,
               valueToStore, dOrImm, BRMI, saveCond, read_enable, ALUOp, regRD,
               pc_en, halted, busy
    );

    modport slave (
        input  run, instr, flags, commandZero, mem_ready,
`ifdef DATAPATH_SEQ_PERF_EN
        output retired, stall_cycles,
`endif
        output uncondBr, brTaken, memWrite, memToReg, ALUSrc, regWrite, reg2Loc,
               valueToStore, dOrImm, BRMI, saveCond, read_enable, ALUOp, regRD,
               pc_en, halted, busy
    );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multicycle FETCH/EXEC/MEM control sequencer for the LEGv8 datapath.
// Optional DATAPATH_SEQ_PERF_EN adds retired-instruction and memory-stall counters.
module datapath_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);
    localparam logic [5:0] OP_ADDI  = 6'b100100;
    localparam logic [5:0] OP_ADDS  = 6'b101010;
    localparam logic [5:0] OP_SUBS  = 6'b111010;
    localparam logic [5:0] OP_LDST  = 6'b111110;
    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [5:0] OP_BL    = 6'b100101;
    localparam logic [5:0] OP_CBZ   = 6'b101101;
    localparam logic [5:0] OP_BCOND = 6'b010101;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    state_t      r_state, w_next;
    logic [11:0] r_ir;
    logic [5:0]  w_op;
    logic [4:0]  w_rd;
    logic        w_ldur, w_stur, w_legal, w_cond, w_z, w_n, w_v;

    assign w_op    = r_ir[5:0];
    assign w_rd    = (w_op == OP_BL) ? 5'd30 : r_ir[11:7];
    assign w_ldur  = (w_op == OP_LDST) && r_ir[6];
    assign w_stur  = (w_op == OP_LDST) && !r_ir[6];
    assign w_legal = w_op inside {OP_ADDI, OP_ADDS, OP_SUBS, OP_LDST, OP_B, OP_BL, OP_CBZ, OP_BCOND};
    assign w_z     = bus.flags[1];
    assign w_n     = bus.flags[0];
    assign w_v     = bus.flags[2];
    assign bus.halted = (r_state == HALT);
    assign bus.busy   = (r_state == FETCH) || (r_state == EXEC) || (r_state == MEM);
    assign bus.BRMI   = 1'b0;

    // State register; asynchronous reset drops straight back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Instruction register, captured once per instruction in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 r_ir <= '0;
        else if (r_state == FETCH) r_ir <= bus.instr;
    end

    // B.cond evaluation of IR condition code against the registered flags
    always_comb begin
        w_cond = 1'b0;
        case (r_ir[10:7])
            4'b0000: w_cond = w_z;
            4'b0001: w_cond = !w_z;
            4'b1010: w_cond = (w_n == w_v);
            4'b1011: w_cond = (w_n != w_v);
            4'b1100: w_cond = !w_z && (w_n == w_v);
            4'b1101: w_cond = w_z || (w_n != w_v);
            default: w_cond = 1'b0;
        endcase
    end

    // Next-state and control decode; everything idles at 0 unless the phase asserts it
    always_comb begin
        w_next           = r_state;
        bus.uncondBr     = 1'b0;
        bus.brTaken      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memToReg     = 1'b0;
        bus.ALUSrc       = 1'b0;
        bus.regWrite     = 1'b0;
        bus.reg2Loc      = 1'b0;
        bus.valueToStore = 1'b0;
        bus.dOrImm       = 1'b0;
        bus.saveCond     = 1'b0;
        bus.read_enable  = 1'b0;
        bus.ALUOp        = 3'b000;
        bus.regRD        = 5'd0;
        bus.pc_en        = 1'b0;
        case (r_state)
            IDLE:  if (bus.run) w_next = FETCH;
            FETCH: w_next = EXEC;
            EXEC: begin
                if (!w_legal) begin
                    w_next = HALT;
                end else if (w_op == OP_LDST) begin
                    bus.regRD  = w_rd;
                    bus.ALUSrc = 1'b1;
                    bus.ALUOp  = 3'b010;
                    w_next     = MEM;
                end else begin
                    bus.regRD = w_rd;
                    bus.pc_en = 1'b1;
                    w_next    = FETCH;
                    case (w_op)
                        OP_ADDI:  begin bus.ALUSrc = 1'b1; bus.dOrImm = 1'b1; bus.ALUOp = 3'b010; bus.regWrite = 1'b1; end
                        OP_ADDS:  begin bus.ALUOp = 3'b010; bus.reg2Loc = 1'b1; bus.regWrite = 1'b1; bus.saveCond = 1'b1; end
                        OP_SUBS:  begin bus.ALUOp = 3'b011; bus.reg2Loc = 1'b1; bus.regWrite = 1'b1; bus.saveCond = 1'b1; end
                        OP_B:     begin bus.uncondBr = 1'b1; bus.brTaken = 1'b1; end
                        OP_BL:    begin bus.uncondBr = 1'b1; bus.brTaken = 1'b1; bus.valueToStore = 1'b1; bus.regWrite = 1'b1; end
                        OP_CBZ:   bus.brTaken = bus.commandZero;
                        OP_BCOND: bus.brTaken = w_cond;
                        default:  bus.brTaken = 1'b0;
                    endcase
                end
            end
            MEM: begin
                bus.regRD       = w_rd;
                bus.ALUSrc      = 1'b1;
                bus.ALUOp       = 3'b010;
                bus.read_enable = w_ldur;
                bus.memWrite    = w_stur;
                if (bus.mem_ready) begin
                    bus.pc_en    = 1'b1;
                    bus.regWrite = w_ldur;
                    bus.memToReg = w_ldur;
                    w_next       = FETCH;
                end
            end
            HALT:    w_next = HALT;
            default: w_next = IDLE;
        endcase
    end

`ifdef DATAPATH_SEQ_PERF_EN
    logic [31:0] r_retired, r_stall_cycles;

    // Retired-instruction and MEM-stall counters, free-running and wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired      <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (bus.pc_en) r_retired <= r_retired + 32'd1;
            if ((r_state == MEM) && !bus.mem_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.retired      = r_retired;
    assign bus.stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: table-driven and scoreboarded checks of the LEGv8 sequencer.
module tb_datapath_sequencer;
    typedef struct {
        logic [11:0] instr;
        logic [3:0]  flags;
        logic        cz;
        logic [19:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   exp_ret = 0;
    int   exp_stall = 0;
    logic [19:0] sb[$];
    vec_t tbl[18];

    always #5 clk = ~clk;

    datapath_sequencer_if bus();
    datapath_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [19:0] ctl(input logic ub, bt, mw, mtr, as, rw, r2l, vts, doi, sc, re,
                                        input logic [2:0] op, input logic [4:0] rd);
        return {ub, bt, mw, mtr, as, rw, r2l, vts, doi, 1'b0, sc, re, op, rd};
    endfunction

    function automatic logic [19:0] act_ctl();
        return {bus.uncondBr, bus.brTaken, bus.memWrite, bus.memToReg, bus.ALUSrc, bus.regWrite,
                bus.reg2Loc, bus.valueToStore, bus.dOrImm, bus.BRMI, bus.saveCond, bus.read_enable,
                bus.ALUOp, bus.regRD};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_instr(input int idx, input vec_t v);
        bit done = 0;
        bus.instr = v.instr;
        bus.flags = v.flags;
        bus.commandZero = v.cz;
        sb.push_back(v.exp);
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk($sformatf("fetch_ctl[%0d]", idx), {12'd0, act_ctl()}, 32'd0);
                chk($sformatf("fetch_pc_busy[%0d]", idx), {30'd0, bus.pc_en, bus.busy}, 32'd1);
            end
            if (bus.pc_en) begin
                done = 1;
                chk($sformatf("exec_ctl[%0d]", idx), {12'd0, act_ctl()}, {12'd0, sb.pop_front()});
                chk($sformatf("exec_latency[%0d]", idx), cyc, 2);
                exp_ret++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            chk($sformatf("exec_timeout[%0d]", idx), 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic mem_op(input string nm, input logic [11:0] ins, input int stalls, input logic ld);
        bit done = 0;
        int re_n = 0, mw_n = 0, rw_n = 0, pc_n = 0;
        bus.instr = ins;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            bus.mem_ready = (cyc <= 2) || (cyc >= 3 + stalls);
            @(negedge clk);
            if (cyc >= 3) begin
                re_n += int'(bus.read_enable);
                mw_n += int'(bus.memWrite);
            end
            rw_n += int'(bus.regWrite);
            pc_n += int'(bus.pc_en);
            if (cyc == 2)
                chk({nm, "_exec_addr"}, {26'd0, bus.ALUSrc, bus.ALUOp, bus.dOrImm, bus.pc_en},
                    {26'd0, 1'b1, 3'b010, 1'b0, 1'b0});
            if (bus.pc_en) begin
                done = 1;
                chk({nm, "_final_rw_mtr"}, {30'd0, bus.regWrite, bus.memToReg}, {30'd0, ld, ld});
                chk({nm, "_latency"}, cyc, 3 + stalls);
                chk({nm, "_rd"}, {27'd0, bus.regRD}, {27'd0, ins[11:7]});
                exp_ret++;
                exp_stall += stalls;
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        if (!done) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_re_cycles"}, re_n, ld ? stalls + 1 : 0);
        chk({nm, "_mw_cycles"}, mw_n, ld ? 0 : stalls + 1);
        chk({nm, "_rw_count"}, rw_n, ld ? 1 : 0);
        chk({nm, "_pc_count"}, pc_n, 1);
    endtask

    initial begin
        int pcn = 0, rwn = 0;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.instr = '0;
        bus.flags = '0;
        bus.commandZero = 1'b0;
        bus.mem_ready = 1'b0;
        tbl[0]  = '{{5'd1, 1'b0, 6'b100100}, 4'b0000, 1'b0, ctl(0,0,0,0,1,1,0,0,1,0,0,3'b010,5'd1)};
        tbl[1]  = '{{5'd2, 1'b0, 6'b101010}, 4'b0000, 1'b0, ctl(0,0,0,0,0,1,1,0,0,1,0,3'b010,5'd2)};
        tbl[2]  = '{{5'd3, 1'b0, 6'b111010}, 4'b0000, 1'b0, ctl(0,0,0,0,0,1,1,0,0,1,0,3'b011,5'd3)};
        tbl[3]  = '{{5'd7, 1'b0, 6'b000101}, 4'b0000, 1'b0, ctl(1,1,0,0,0,0,0,0,0,0,0,3'b000,5'd7)};
        tbl[4]  = '{{5'd5, 1'b0, 6'b100101}, 4'b0000, 1'b0, ctl(1,1,0,0,0,1,0,1,0,0,0,3'b000,5'd30)};
        tbl[5]  = '{{5'd4, 1'b0, 6'b101101}, 4'b0000, 1'b1, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd4)};
        tbl[6]  = '{{5'd4, 1'b0, 6'b101101}, 4'b0000, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd4)};
        tbl[7]  = '{{5'b00000, 1'b0, 6'b010101}, 4'b0010, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd0)};
        tbl[8]  = '{{5'b00001, 1'b0, 6'b010101}, 4'b0010, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd1)};
        tbl[9]  = '{{5'b01010, 1'b0, 6'b010101}, 4'b0101, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd10)};
        tbl[10] = '{{5'b01011, 1'b0, 6'b010101}, 4'b0001, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd11)};
        tbl[11] = '{{5'b01100, 1'b0, 6'b010101}, 4'b0000, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd12)};
        tbl[12] = '{{5'b01101, 1'b0, 6'b010101}, 4'b0000, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd13)};
        tbl[13] = '{{5'b00010, 1'b0, 6'b010101}, 4'b1111, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd2)};
        tbl[14] = '{{5'b01100, 1'b0, 6'b010101}, 4'b0010, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd12)};
        tbl[15] = '{{5'b01101, 1'b0, 6'b010101}, 4'b0010, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd13)};
        tbl[16] = '{{5'b00000, 1'b0, 6'b010101}, 4'b0000, 1'b0, ctl(0,0,0,0,0,0,0,0,0,0,0,3'b000,5'd0)};
        tbl[17] = '{{5'b10000, 1'b0, 6'b010101}, 4'b0010, 1'b0, ctl(0,1,0,0,0,0,0,0,0,0,0,3'b000,5'd16)};

        @(negedge clk);
        chk("reset_ctl", {12'd0, act_ctl()}, 32'd0);
        chk("reset_pc_halt_busy", {29'd0, bus.pc_en, bus.halted, bus.busy}, 32'd0);
`ifdef DATAPATH_SEQ_PERF_EN
        chk("reset_retired", bus.retired, 32'd0);
        chk("reset_stalls", bus.stall_cycles, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;

        for (int i = 0; i < 18; i++) do_instr(i, tbl[i]);
        mem_op("ldur_stall3", {5'd9, 1'b1, 6'b111110}, 3, 1'b1);
        mem_op("ldur_fast", {5'd8, 1'b1, 6'b111110}, 0, 1'b1);
        mem_op("stur_stall2", {5'd3, 1'b0, 6'b111110}, 2, 1'b0);
        do_instr(100, tbl[0]);
`ifdef DATAPATH_SEQ_PERF_EN
        chk("perf_retired", bus.retired, exp_ret);
        chk("perf_stalls", bus.stall_cycles, exp_stall);
`endif

        bus.instr = {5'd6, 1'b0, 6'b111110};
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stur_mem_wr", {31'd0, bus.memWrite}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("stur_reset_drop", {29'd0, bus.memWrite, bus.busy, bus.pc_en}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.instr = {5'd1, 1'b0, 6'b000000};
        for (int c = 1; c <= 8; c++) begin
            bus.run = (c >= 4);
            @(negedge clk);
            pcn += int'(bus.pc_en);
            rwn += int'(bus.regWrite);
            if (c == 2) chk("halt_exec", {30'd0, bus.halted, bus.busy}, 32'd1);
            if (c == 3) chk("halt_enter", {30'd0, bus.halted, bus.busy}, 32'd2);
            @(posedge clk); #1;
        end
        chk("halt_no_pc_en", pcn, 0);
        chk("halt_no_regwrite", rwn, 0);
        chk("halt_sticky", {30'd0, bus.halted, bus.busy}, 32'd2);
        reset = 1'b1;
        #1 chk("halt_cleared", {29'd0, bus.halted, bus.busy, bus.pc_en}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multicycle control sequencer for the LEGv8 single-cycle datapath. It drives every datapath control input from the 12-bit decoded instruction slice (`instr`), the condition flags and `commandZero`. It steps each instruction through FETCH/EXEC/optional MEM phases, gates PC advance with `pc_en`, and stalls on a memory-ready handshake. Illegal opcodes force a sticky halt.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `run`  in  1  leave IDLE and begin sequencing
- `instr`  in  12  [5:0] = opcode bits 31:26; [6] = bit 22; [11:7] = bits 4:0 (Rd/Rt, cond in [10:7])
- `flags`  in  4  registered {C,V,Z,N} = {[3],[2],[1],[0]}
- `commandZero`  in  1  live ALU zero
- `mem_ready`  in  1  data memory access complete
- `uncondBr, brTaken, memWrite, memToReg, ALUSrc, regWrite, reg2Loc, valueToStore, dOrImm, BRMI, saveCond, read_enable`  out  1 each  datapath controls
- `ALUOp`  out  3  000 pass B, 010 add, 011 sub
- `regRD`  out  5  write register address
- `pc_en`  out  1  PC update strobe
- `halted`  out  1  illegal opcode trap, sticky
- `busy`  out  1  high in any state except IDLE/HALT

## Operation
States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE → FETCH when `run`=1. All controls 0.
- FETCH: latch `instr` into internal IR; all controls 0; → EXEC. Decode uses IR only.
- Decode of IR[5:0] (IR[6] splits LDUR/STUR):
  - ADDI 100100: ALUSrc=1, dOrImm=1, ALUOp=010, regWrite.
  - ADDS 101010: ALUOp=010, reg2Loc=1, regWrite, saveCond.
  - SUBS 111010: ALUOp=011, reg2Loc=1, regWrite, saveCond.
  - LDUR 111110/bit22=1: ALUSrc=1, dOrImm=0, ALUOp=010, read_enable, memToReg.
  - STUR 111110/bit22=0: ALUSrc=1, dOrImm=0, ALUOp=010, reg2Loc=0, memWrite.
  - B 000101: uncondBr=1, brTaken=1.
  - BL 100101: uncondBr=1, brTaken=1, valueToStore=1, regWrite, regRD=30.
  - CBZ 101101: reg2Loc=0, ALUOp=000, brTaken=commandZero.
  - B.cond 010101: brTaken = cond(IR[10:7], flags).
    - EQ 0000 = Z; NE 0001 = !Z; GE 1010 = N==V; LT 1011 = N!=V; GT 1100 = !Z&&N==V; LE 1101 = Z||N!=V.
    - Any other cond code: not taken.
  - Any other opcode → HALT. No regWrite or pc_en is issued for it.
- EXEC:
  - Non-memory ops: controls asserted for exactly this cycle, pc_en=1, → FETCH.
  - LDUR/STUR: address controls asserted, → MEM.
- MEM: address controls held; read_enable (LDUR) or memWrite (STUR) held.
  - `mem_ready`=0: stay in MEM.
  - `mem_ready`=1: regWrite (LDUR only), pc_en=1, → FETCH.
- `regRD` = IR[11:7] except BL (30). BRMI is always 0.
- HALT: `halted`=1, all controls 0. Left only by reset.

## Timing
- Reset: state IDLE; every output 0, including `regRD`, `halted` and `busy`.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - LDUR/STUR: 3 cycles plus one cycle per `mem_ready`-low cycle in MEM.
- Outputs are combinational from state and IR. They are stable for the whole cycle in which the datapath samples them.
- regWrite, saveCond and pc_en each assert for exactly one cycle per instruction.
- Flags written by ADDS/SUBS are visible to any following B.cond, which reaches EXEC at least 2 cycles later.
- `run` is sampled only in IDLE. Deasserting it mid-instruction has no effect.
- `mem_ready` outside MEM is ignored. If `mem_ready`=1 on the first MEM cycle, the access completes in 1 cycle.
- Reset asserted mid-MEM: immediate return to IDLE. memWrite/read_enable drop asynchronously.

## Configuration
- `DATAPATH_SEQ_PERF_EN`: adds outputs `retired[31:0]` and `stall_cycles[31:0]`. Both reset to 0.
  - `retired` increments on each pc_en.
  - `stall_cycles` increments each MEM cycle with `mem_ready`=0.
  - Both wrap modulo 2^32.
- Without the macro: neither port nor counter exists. Core behaviour is identical.

## Test plan
- Reset, then `run`=1, then ADDI X1 (instr = {5'd1, 1'b0, 6'b100100}) → EXEC shows ALUOp=010, ALUSrc=1, dOrImm=1, regWrite=1, regRD=1, pc_en=1; 2 cycles total.
- LDUR with `mem_ready` low for 3 cycles → read_enable held 4 MEM cycles; regWrite, memToReg and pc_en only in the final cycle; stall_cycles=3 (PERF build).
- SUBS setting Z, then B.cond EQ (cond 0000) → brTaken=1. Repeat with NE (0001) → brTaken=0.
- CBZ with commandZero=1 → brTaken=1. BL → regRD=30, valueToStore=1, uncondBr=1.
- Opcode 000000 → HALT, halted=1, no pc_en. `run` pulses ignored until reset clears halted to 0.
- Reset asserted during a MEM stall of STUR → memWrite=0 the same cycle, state IDLE, busy=0.
